// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the 4-channel receive-side demux.
//   NUM_CH / CH_W : channel count and width of the binary channel code.
//   slot_state_e  : per-slot occupancy state.
//   dec2to4       : binary code -> one-hot enable, identical to the source-side select decode.
//   popcount4     : number of set bits in a 4-bit vector.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_CH-1:0] dec2to4(input logic [CH_W-1:0] code);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

    function automatic logic [2:0] popcount4(input logic [NUM_CH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/demux_with_encoder_slot.sv
// demux_slot: one-deep holding register for a single output channel.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data).
//   wr_en      : write the incoming word this cycle.
//   wr_data    : incoming word.
//   ack        : consumer takes the held word this cycle (ignored when empty).
//   data       : held word.
//   valid      : slot holds an unconsumed word.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_e      state_p1;
    logic [WIDTH-1:0] data_p1;

    // Stage 1: slot register, one cycle from write to visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= SLOT_EMPTY;
            data_p1  <= '0;
        end else begin
            case (state_p1)
                SLOT_EMPTY: begin
                    if (wr_en) begin
                        state_p1 <= SLOT_FULL;
                        data_p1  <= wr_data;
                    end
                end
                SLOT_FULL: begin
                    // A write is only honoured together with an ack (bypass refill);
                    // a full, un-acked slot is never overwritten.
                    if (ack) begin
                        if (wr_en) begin
                            data_p1 <= wr_data;
                        end else begin
                            state_p1 <= SLOT_EMPTY;
                        end
                    end
                end
                default: state_p1 <= SLOT_EMPTY;
            endcase
        end
    end

    assign data  = data_p1;
    assign valid = (state_p1 == SLOT_FULL);

endmodule

// File: rtl/demux_with_encoder.sv
// demux_with_encoder: routes a bus word to one of four one-deep channel slots.
//   clk, rst_n : clock, asynchronous active-low reset.
//   d          : binary channel code selecting the target slot.
//   y          : bus data word.
//   in_valid   : upstream offers y to channel d.
//   in_ready   : offer accepted this cycle (combinational).
//   ch_data    : slot k contents at [k*WIDTH +: WIDTH].
//   ch_valid   : slot k holds an unconsumed word.
//   ch_ack     : consumer k takes its word.
//   occupancy  : number of full slots (0..4).
module demux_with_encoder
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_W-1:0]         d,
    input  logic [WIDTH-1:0]        y,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ack,
    output logic [2:0]              occupancy
);

    logic [NUM_CH-1:0] sel_oh;
    logic              accept;
    logic [NUM_CH-1:0] wr_en;
    logic              inc;
    logic [2:0]        dec;
    logic [2:0]        occ_p1;

    assign sel_oh   = dec2to4(d);
    // Only the addressed slot gates ready; an ack on it frees it in the same cycle.
    assign in_ready = ~ch_valid[d] | ch_ack[d];
    assign accept   = in_valid & in_ready;
    assign wr_en    = accept ? sel_oh : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[k]),
            .wr_data (y),
            .ack     (ch_ack[k]),
            .data    (ch_data[k*WIDTH +: WIDTH]),
            .valid   (ch_valid[k])
        );
    end

    // Refilling an acked slot leaves its count unchanged, so it is neither inc nor dec.
    assign inc = accept & ~ch_valid[d];
    assign dec = popcount4(ch_ack & ch_valid & ~wr_en);

    // Stage 1: occupancy counter, tracks popcount(ch_valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_p1 <= '0;
        end else begin
            occ_p1 <= occ_p1 + {2'b00, inc} - dec;
        end
    end

    assign occupancy = occ_p1;

endmodule

// File: tb/tb_demux_with_encoder.sv
module tb_demux_with_encoder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  d;
    logic [7:0]  y;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ack;
    logic [2:0]  occupancy;

    int tests;
    int fails;

    logic [3:0]  mv;
    logic [31:0] md;
    logic        mready;

    demux_with_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .ch_ack    (ch_ack),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] dd, input logic [7:0] yy, input logic [3:0] ack);
        in_valid = 1'b1;
        d        = dd;
        y        = yy;
        ch_ack   = ack;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        ch_ack   = 4'b0000;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        d        = 2'd0;
        y        = 8'h00;
        in_valid = 1'b0;
        ch_ack   = 4'b0000;
        #1;
        check("rst_valid", {28'd0, ch_valid}, 32'h0);
        check("rst_occ",   {29'd0, occupancy}, 32'h0);
        check("rst_ready", {31'd0, in_ready}, 32'h1);
        check("rst_data",  ch_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Basic routing A1..A4 to channels 0..3
        for (int k = 0; k < 4; k++) begin
            offer(k[1:0], 8'hA1 + k[7:0], 4'b0000);
            #1;
            check("route_ready", {31'd0, in_ready}, 32'h1);
            step();
        end
        idle();
        check("route_valid", {28'd0, ch_valid}, 32'hF);
        check("route_data",  ch_data, 32'hA4A3A2A1);
        check("route_occ",   {29'd0, occupancy}, 32'h4);

        // Backpressure on full slot 2
        offer(2'd2, 8'h55, 4'b0000);
        #1;
        check("bp_ready", {31'd0, in_ready}, 32'h0);
        step();
        check("bp_slot2", {24'd0, ch_data[23:16]}, 32'hA3);
        check("bp_occ",   {29'd0, occupancy}, 32'h4);
        ch_ack = 4'b0010;
        #1;
        check("bp_ready_ack1", {31'd0, in_ready}, 32'h0);
        step();
        check("bp_valid", {28'd0, ch_valid}, 32'hD);
        check("bp_slot2b", {24'd0, ch_data[23:16]}, 32'hA3);
        check("bp_occ2",  {29'd0, occupancy}, 32'h3);

        // Drain everything, then put 10 in slot 3
        in_valid = 1'b0;
        ch_ack   = 4'b1111;
        step();
        check("drain_valid", {28'd0, ch_valid}, 32'h0);
        check("drain_occ",   {29'd0, occupancy}, 32'h0);
        offer(2'd3, 8'h10, 4'b0000);
        step();
        check("fill3_occ", {29'd0, occupancy}, 32'h1);

        // Bypass refill of slot 3
        offer(2'd3, 8'h20, 4'b1000);
        #1;
        check("byp_ready", {31'd0, in_ready}, 32'h1);
        step();
        idle();
        check("byp_valid", {28'd0, ch_valid}, 32'h8);
        check("byp_slot3", {24'd0, ch_data[31:24]}, 32'h20);
        check("byp_occ",   {29'd0, occupancy}, 32'h1);

        // Build slots 0,1,2 full with slot 3 empty
        offer(2'd0, 8'hB0, 4'b1000);
        step();
        offer(2'd1, 8'hB1, 4'b0000);
        step();
        offer(2'd2, 8'hB2, 4'b0000);
        step();
        idle();
        check("pd_pre_valid", {28'd0, ch_valid}, 32'h7);
        check("pd_pre_occ",   {29'd0, occupancy}, 32'h3);

        // Parallel drain of 0..2 while writing 3
        offer(2'd3, 8'h77, 4'b0111);
        #1;
        check("pd_ready", {31'd0, in_ready}, 32'h1);
        step();
        idle();
        check("pd_valid", {28'd0, ch_valid}, 32'h8);
        check("pd_slot3", {24'd0, ch_data[31:24]}, 32'h77);
        check("pd_occ",   {29'd0, occupancy}, 32'h1);

        // Slots 0 and 2 full, then reset mid-traffic
        offer(2'd0, 8'hC0, 4'b1000);
        step();
        offer(2'd2, 8'hC2, 4'b0000);
        step();
        check("mr_pre_valid", {28'd0, ch_valid}, 32'h5);
        offer(2'd1, 8'hC1, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", {28'd0, ch_valid}, 32'h0);
        check("mr_occ",   {29'd0, occupancy}, 32'h0);
        check("mr_ready", {31'd0, in_ready}, 32'h1);
        check("mr_data",  ch_data, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Spurious acks on empty slots
        ch_ack = 4'b1111;
        step();
        ch_ack = 4'b0000;
        check("sp_valid", {28'd0, ch_valid}, 32'h0);
        check("sp_occ",   {29'd0, occupancy}, 32'h0);

        // Random stress against a reference model
        mv = 4'b0000;
        md = 32'h0;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            d        = 2'($urandom_range(0, 3));
            y        = 8'($urandom);
            ch_ack   = 4'($urandom) & 4'($urandom);
            #1;
            mready = ~mv[d] | ch_ack[d];
            check("rs_ready", {31'd0, in_ready}, {31'd0, mready});
            for (int k = 0; k < 4; k++) begin
                if (in_valid && mready && d == k[1:0]) begin
                    mv[k] = 1'b1;
                    md[k*8 +: 8] = y;
                end else if (ch_ack[k]) begin
                    mv[k] = 1'b0;
                end
            end
            step();
            check("rs_valid", {28'd0, ch_valid}, {28'd0, mv});
            for (int k = 0; k < 4; k++) begin
                if (mv[k]) check("rs_data", {24'd0, ch_data[k*8 +: 8]}, {24'd0, md[k*8 +: 8]});
            end
            check("rs_occ", {29'd0, occupancy}, 32'($countones(mv)));
            check("rs_occ_pop", {29'd0, occupancy}, 32'($countones(ch_valid)));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
